// File: rtl/cscfg_cmd_master.sv
// Byte-stream command bridge: parses framed read/write requests, drives the
// master side of intf_cmd (flattened onto o_cmd_*/i_cmd_*) and streams back status plus read data.
module cscfg_cmd_master #(
    parameter int CMD_DATA_BITS  = 32,
    parameter int ADDR_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_sysclk,
    input  logic                      i_srst,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_busy,
    output logic                      o_cmd_sel,
    output logic                      o_cmd_rd_wr_n,
    output logic [8*ADDR_BYTES-1:0]   o_cmd_byte_addr,
    output logic [CMD_DATA_BITS-1:0]  o_cmd_wdata,
    input  logic [CMD_DATA_BITS-1:0]  i_cmd_rdata,
    input  logic                      i_cmd_ack,
    output logic [2:0]                o_state
);
    localparam int NDB  = CMD_DATA_BITS / 8;
    localparam int AW   = 8 * ADDR_BYTES;
    localparam int DW   = CMD_DATA_BITS;
    localparam int MAXB = (ADDR_BYTES > NDB) ? ADDR_BYTES : NDB;
    localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ADDR        = 3'd1;
    localparam logic [2:0] S_WDATA       = 3'd2;
    localparam logic [2:0] S_ISSUE       = 3'd3;
    localparam logic [2:0] S_WAIT_ACK    = 3'd4;
    localparam logic [2:0] S_RESP_STATUS = 3'd5;
    localparam logic [2:0] S_RESP_DATA   = 3'd6;

    localparam logic [7:0] OP_WRITE      = 8'h57;
    localparam logic [7:0] OP_READ       = 8'h52;
    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_TIMEOUT    = 8'h01;
    localparam logic [7:0] ST_BAD_OPCODE = 8'h02;

    localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(NDB - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]     state_q, state_d;
    logic           rx_ready_q, rx_ready_d;
    logic           sel_q, sel_d;
    logic           rd_wr_n_q, rd_wr_n_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [TW-1:0]  to_inc;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           rx_acc, tx_acc;

    assign rx_acc = rx_ready_q & i_rx_valid;
    assign tx_acc = tx_valid_q & i_tx_ready;
    assign to_inc = (to_cnt_q == {TW{1'b1}}) ? to_cnt_q : to_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rd_wr_n_d  = rd_wr_n_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        bcnt_d     = bcnt_q;
        to_cnt_d   = to_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            S_IDLE: if (rx_acc) begin
                bcnt_d = '0;
                if (i_rx_data == OP_WRITE) begin
                    rd_wr_n_d = 1'b0;
                    state_d   = S_ADDR;
                end else if (i_rx_data == OP_READ) begin
                    rd_wr_n_d = 1'b1;
                    state_d   = S_ADDR;
                end else begin
                    tx_data_d  = ST_BAD_OPCODE;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP_STATUS;
                end
            end
            S_ADDR: if (rx_acc) begin
                addr_d = (addr_q >> 8) | (AW'(i_rx_data) << (AW - 8));
                if (bcnt_q == ADDR_LAST) begin
                    bcnt_d  = '0;
                    state_d = rd_wr_n_q ? S_ISSUE : S_WDATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_WDATA: if (rx_acc) begin
                wdata_d = (wdata_q >> 8) | (DW'(i_rx_data) << (DW - 8));
                if (bcnt_q == DATA_LAST) begin
                    bcnt_d  = '0;
                    state_d = S_ISSUE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Ack is checked first so it wins over a timeout in the same cycle;
                // expiry lands the status byte TIMEOUT_CYCLES cycles after sel.
                if (i_cmd_ack) begin
                    rdata_d    = i_cmd_rdata;
                    tx_data_d  = ST_OK;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP_STATUS;
                end else if (to_inc == TO_LAST) begin
                    tx_data_d  = ST_TIMEOUT;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP_STATUS;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            S_RESP_STATUS: if (tx_acc) begin
                if (rd_wr_n_q && (tx_data_q == ST_OK)) begin
                    tx_data_d = rdata_q[7:0];
                    rdata_d   = rdata_q >> 8;
                    bcnt_d    = '0;
                    state_d   = S_RESP_DATA;
                end else begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_RESP_DATA: if (tx_acc) begin
                if (bcnt_q == DATA_LAST) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    tx_data_d = rdata_q[7:0];
                    rdata_d   = rdata_q >> 8;
                    bcnt_d    = bcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready and sel are registered from the next state so both are glitch-free.
    assign rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
    assign sel_d      = (state_d == S_ISSUE);

    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            sel_q      <= 1'b0;
            rd_wr_n_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            bcnt_q     <= '0;
            to_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            sel_q      <= sel_d;
            rd_wr_n_q  <= rd_wr_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            bcnt_q     <= bcnt_d;
            to_cnt_q   <= to_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign o_rx_ready      = rx_ready_q;
    assign o_tx_data       = tx_data_q;
    assign o_tx_valid      = tx_valid_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_cmd_sel       = sel_q;
    assign o_cmd_rd_wr_n   = rd_wr_n_q;
    assign o_cmd_byte_addr = addr_q;
    assign o_cmd_wdata     = wdata_q;
    assign o_state         = state_q;
endmodule

// File: doc/cscfg_cmd_master.md
Name: cscfg_cmd_master

Overview:
- Byte-stream command bridge that sits directly upstream of the cscfg command slave.
- Parses framed read/write requests from a byte stream, such as the UART/host link deserializer.
- Drives the master side of intf_cmd with a single-cycle sel pulse, then waits for ack with a timeout.
- Returns a status byte, plus read data for reads, on an outbound byte stream.

Parameters:
- CMD_DATA_BITS, 32, width of wdata/rdata; must be a multiple of 8; NDB = CMD_DATA_BITS/8 data bytes per frame.
- ADDR_BYTES, 2, number of address bytes in a frame; byte_addr width = 8*ADDR_BYTES.
- TIMEOUT_CYCLES, 255, cycles to wait for ack after sel before declaring a timeout; must be ≥ 2.

Ports:
- i_sysclk  input  1  system clock
- i_srst  input  1  synchronous reset, active-high
- i_rx_data  input  8  inbound request byte
- i_rx_valid  input  1  inbound byte valid
- o_rx_ready  output  1  inbound byte accepted when valid & ready
- o_tx_data  output  8  outbound response byte
- o_tx_valid  output  1  outbound byte valid
- i_tx_ready  input  1  outbound byte consumed when valid & ready
- o_busy  output  1  high whenever state != IDLE
- cmd  intf_cmd.master  -  drives sel, rd_wr_n, byte_addr, wdata; samples rdata, ack

Behaviour:
- Clocking/reset: one clock (i_sysclk); reset synchronous, active-high (i_srst).
- Reset values: state=IDLE; o_rx_ready=0; o_tx_valid=0; o_tx_data=0; o_busy=0; cmd.sel=0; cmd.rd_wr_n=1; cmd.byte_addr=0; cmd.wdata=0; all counters=0.
- Reset mid-operation: abandons the frame, emits no response, and forces sel low on the next edge.
- Request frame: opcode byte, then ADDR_BYTES address bytes LSB first.
  - Write opcode is 0x57; a write frame additionally carries NDB data bytes LSB first.
  - Read opcode is 0x52.
- Response frame: one status byte, then NDB rdata bytes LSB first, sent only for a read with status OK.
  - Status codes: 0x00 OK, 0x01 TIMEOUT, 0x02 BAD_OPCODE.
- States:
  - IDLE: o_rx_ready=1. On accept: 0x57 or 0x52 latches rd_wr_n (1 for read) and goes to ADDR. Any other byte loads status 0x02 and goes to RESP_STATUS; only that single byte is consumed.
  - ADDR: o_rx_ready=1. Shifts bytes into byte_addr LSB first. After ADDR_BYTES bytes, a write goes to WDATA and a read goes to ISSUE.
  - WDATA: o_rx_ready=1. Shifts NDB bytes into wdata LSB first, then goes to ISSUE.
  - ISSUE: cmd.sel=1 for exactly this one cycle; timeout counter cleared; next state WAIT_ACK. byte_addr, wdata and rd_wr_n stay stable from ISSUE until the response completes.
  - WAIT_ACK: sel=0. On cmd.ack=1, capture cmd.rdata in that same cycle (the slave registers rdata and ack together), load status 0x00, go to RESP_STATUS. Otherwise increment the counter; when it reaches TIMEOUT_CYCLES, load 0x01 and go to RESP_STATUS.
  - RESP_STATUS: o_tx_valid=1 with the status byte. On handshake: a read with OK status goes to RESP_DATA; everything else goes to IDLE.
  - RESP_DATA: presents the captured rdata bytes LSB first. After the NDB-th handshake, goes to IDLE.
- Minimum write latency: exactly 1 cycle from the last request byte accepted to sel high.
- o_rx_ready is 0 in ISSUE, WAIT_ACK, RESP_*: no pipelining of frames.
- Backpressure: o_tx_data/o_tx_valid are registered and held stable while valid & !ready. There are no bubbles between response bytes when i_tx_ready stays high.
- Simultaneous ack and timeout expiry in the same cycle: ack wins, status 0x00.
- ack seen in any state other than WAIT_ACK (stray or late): ignored, no state change. A late ack after a timeout must not corrupt the next transaction's captured rdata.
- i_rx_valid gaps inside a frame: the parser waits indefinitely; there is no inter-byte timeout.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Test Plan:
- Write: rx 57 04 00 EF BE AD DE → one sel pulse with rd_wr_n=0, byte_addr=0x0004, wdata=0xDEADBEEF; tx 00.
- Readback: after the write, rx 52 04 00 → sel pulse with rd_wr_n=1, byte_addr=0x0004; tx 00 EF BE AD DE.
- Undecoded read: rx 52 08 00 against the cscfg slave → tx 00 EF BE AD DE (slave default 0xDEADBEEF).
- Timeout: slave held with ack=0, rx 52 04 00 → tx 01 exactly TIMEOUT_CYCLES=255 cycles after sel, with no data bytes. A forced stray ack 3 cycles later is ignored, and the next read returns correct data.
- Bad opcode then recovery: rx 41 57 04 00 01 00 00 00 → tx 02, then tx 00, with wdata=0x00000001 at byte_addr=4.
- Backpressure and reset: during a readback, hold i_tx_ready=0 for 10 cycles on the 2nd data byte → o_tx_data stays 0xBE and no byte is lost or duplicated. Separately, assert i_srst in WAIT_ACK → next cycle sel=0, tx_valid=0, state IDLE, and no response is ever emitted for that frame.
